wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback stage of the 5-stage pipeline. Sits between the MEM stage and regfile, and drives regfile's rd_wen_i, rd_idx_i and rd_wdata_i.
- Registers the MEM result and waits for the data-memory response on loads.
- Performs load byte/half/word selection and sign/zero extension.
- Emits one commit pulse per retired instruction and keeps a retired-instruction counter.

Parameters:
- INSTRET_W, 64, width of the retired-instruction counter.
- XLEN is not a parameter; it comes from the `XLEN define (64).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- mem_valid_i  in  1  MEM stage presents an instruction
- wb_ready_o  out  1  stage can accept; transfer when mem_valid_i && wb_ready_o
- mem_pc_i  in  XLEN  PC of the presented instruction
- mem_rd_wen_i  in  1  instruction writes rd
- mem_rd_idx_i  in  5  destination register
- mem_alu_res_i  in  XLEN  ALU/CSR result; for loads, the effective address (only bits [2:0] are used)
- mem_is_load_i  in  1  instruction is a load
- mem_ld_funct3_i  in  3  load type: LB, LH, LW, LD, LBU, LHU, LWU
- dmem_rvalid_i  in  1  data-memory read response valid
- dmem_rdata_i  in  XLEN  aligned 64-bit doubleword read data
- rd_wen_o  out  1  regfile write enable
- rd_idx_o  out  5  regfile write index
- rd_wdata_o  out  XLEN  regfile write data
- commit_valid_o  out  1  one-cycle pulse per retired instruction
- commit_pc_o  out  XLEN  PC of the retiring instruction
- instret_o  out  INSTRET_W  retired-instruction count

Behaviour:
- Reset values:
  - state = IDLE
  - wb_ready_o = 1
  - rd_wen_o, commit_valid_o = 0
  - rd_idx_o, rd_wdata_o, commit_pc_o, instret_o = 0
- FSM states: IDLE, WAIT_LD. wb_ready_o = (state == IDLE); it is purely Moore.
- IDLE, accept of a non-load at cycle N:
  - In cycle N+1: commit_valid_o = 1, commit_pc_o = pc.
  - In cycle N+1: rd_wen_o = mem_rd_wen_i && (rd_idx != 0); rd_idx_o = idx; rd_wdata_o = alu_res.
  - State stays IDLE, so back-to-back accepts give one retire per cycle.
- IDLE, accept of a load:
  - Latch pc, rd_wen, rd_idx, funct3 and addr[2:0].
  - Go to WAIT_LD. No outputs are asserted.
- WAIT_LD:
  - If dmem_rvalid_i in cycle M: in cycle M+1 assert commit/regfile outputs with the extracted data, and return to IDLE.
  - The earliest possible M is accept+1, giving load-to-write latency ≥ 2 cycles.
  - wb_ready_o stays low through cycle M and is high from M+1.
- dmem_rvalid_i in IDLE (including in the same cycle as the load accept) is ignored; no state change.
- Load extraction:
  - byte = rdata[8*off +: 8], where off = addr[2:0]
  - half = rdata[16*off[2:1] +: 16]
  - word = rdata[32*off[2] +: 32]
  - dword = rdata
  - Address bits finer than the access size are ignored; misaligned accesses are not detected here.
  - LB/LH/LW sign-extend to XLEN; LBU/LHU/LWU zero-extend. LD passes through.
  - Any undefined funct3 behaves as LD.
- rd_wen_o, rd_idx_o, rd_wdata_o and commit_valid_o are registered outputs, high for exactly one cycle per retire.
  - When idle, rd_idx_o, rd_wdata_o and commit_pc_o hold their last values.
- rd_idx = 0 with wen = 1: the instruction still commits and instret increments, but rd_wen_o = 0.
- instret_o increments by 1 in the same cycle commit_valid_o is high, and wraps from all-ones to 0.
- Reset mid-WAIT_LD: the pending load is dropped with no commit and no write, and all registers take their reset values.
- No flush input: anything reaching MEM is architecturally committed.

Decomposition:
- defines.v:
  - load funct3 constants `LD_LB 3'b000, `LD_LH 3'b001, `LD_LW 3'b010, `LD_LD 3'b011, `LD_LBU 3'b100, `LD_LHU 3'b101, `LD_LWU 3'b110
  - FSM state encodings `WB_IDLE, `WB_WAIT_LD
  - existing `XLEN and `REG_X0 are reused
- Sub-module: wb_load_ext (combinational: funct3, off[2:0], rdata → XLEN result). It is reused later by the misaligned-load handler.

Test Plan:
- Non-load ADD: accept pc=0x1000, rd=5, res=0x1234 at cycle 3 → cycle 4 has rd_wen_o=1, rd_idx_o=5, rd_wdata_o=0x1234, commit_pc_o=0x1000, and instret_o goes 0→1.
- Back-to-back: 4 ALU ops on consecutive cycles → wb_ready_o never drops, 4 consecutive commit pulses, instret_o=4.
- Load extraction with rdata=0x8899AABB_CCDDEEFF:
  - LB off=1 → 0xFFFFFFFF_FFFFFFEE
  - LBU off=7 → 0x88
  - LH off=6 → 0xFFFFFFFF_FFFF8899
  - LWU off=4 → 0x8899AABB
  - LW off=0 → 0xFFFFFFFF_CCDDEEFF
  - LD → full value
- Load wait: accept LW at cycle 10, rvalid at cycle 14 → wb_ready_o is low in cycles 11–14, write/commit in cycle 15, next accept possible at 15. A spurious rvalid in IDLE → no effect.
- x0 destination: rd=0, wen=1, res=0xDEAD → rd_wen_o stays 0, commit_valid_o=1, instret increments.
- Reset in WAIT_LD: rst at cycle 12 with a load pending, then rvalid at cycle 13 → no write, no commit, instret_o=0, wb_ready_o=1.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the writeback stage: load funct3 codes,
// FSM states and the record of a load waiting for its memory response.
package wb_stage_pkg;

   localparam int XLEN = 64;
   localparam logic [4:0] REG_X0 = 5'd0;

   typedef enum logic [2:0] {
      LD_LB  = 3'b000,
      LD_LH  = 3'b001,
      LD_LW  = 3'b010,
      LD_LD  = 3'b011,
      LD_LBU = 3'b100,
      LD_LHU = 3'b101,
      LD_LWU = 3'b110
   } ld_funct3_e;

   typedef enum logic {
      WB_IDLE    = 1'b0,
      WB_WAIT_LD = 1'b1
   } wb_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic            rd_wen;
      logic [4:0]      rd_idx;
      logic [2:0]      funct3;
      logic [2:0]      off;
   } pend_ld_t;

endpackage

// File: rtl/wb_stage_load_ext.sv
// Combinational load data extraction: picks the byte/half/word lane from an
// aligned doubleword and sign- or zero-extends it. Reused by the misaligned-load path.
module wb_load_ext
   import wb_stage_pkg::*;
(
   input  logic [2:0]      funct3_i,
   input  logic [2:0]      off_i,
   input  logic [XLEN-1:0] rdata_i,
   output logic [XLEN-1:0] result_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [31:0] word_v;
   logic [5:0]  byte_lsb;
   logic [5:0]  half_lsb;
   logic [5:0]  word_lsb;

   // Offset bits finer than the access size are dropped, so misaligned
   // addresses silently select the containing naturally-aligned lane.
   always_comb begin
      byte_lsb = {off_i, 3'b000};
      half_lsb = {off_i[2:1], 4'b0000};
      word_lsb = {off_i[2], 5'b00000};
      byte_v   = rdata_i[byte_lsb +: 8];
      half_v   = rdata_i[half_lsb +: 16];
      word_v   = rdata_i[word_lsb +: 32];
   end

   always_comb begin
      result_o = rdata_i;
      case (funct3_i)
         LD_LB:   result_o = {{(XLEN-8){byte_v[7]}}, byte_v};
         LD_LH:   result_o = {{(XLEN-16){half_v[15]}}, half_v};
         LD_LW:   result_o = {{(XLEN-32){word_v[31]}}, word_v};
         LD_LBU:  result_o = {{(XLEN-8){1'b0}}, byte_v};
         LD_LHU:  result_o = {{(XLEN-16){1'b0}}, half_v};
         LD_LWU:  result_o = {{(XLEN-32){1'b0}}, word_v};
         default: result_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: registers MEM results, waits for load data, drives the
// regfile write port, emits commit pulses and counts retired instructions.
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int INSTRET_W = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mem_valid_i,
   output logic                 wb_ready_o,
   input  logic [XLEN-1:0]      mem_pc_i,
   input  logic                 mem_rd_wen_i,
   input  logic [4:0]           mem_rd_idx_i,
   input  logic [XLEN-1:0]      mem_alu_res_i,
   input  logic                 mem_is_load_i,
   input  logic [2:0]           mem_ld_funct3_i,
   input  logic                 dmem_rvalid_i,
   input  logic [XLEN-1:0]      dmem_rdata_i,
   output logic                 rd_wen_o,
   output logic [4:0]           rd_idx_o,
   output logic [XLEN-1:0]      rd_wdata_o,
   output logic                 commit_valid_o,
   output logic [XLEN-1:0]      commit_pc_o,
   output logic [INSTRET_W-1:0] instret_o
);

   wb_state_e             state_q, state_d;
   pend_ld_t              pend_q, pend_d;
   logic                  rd_wen_q, rd_wen_d;
   logic [4:0]            rd_idx_q, rd_idx_d;
   logic [XLEN-1:0]       rd_wdata_q, rd_wdata_d;
   logic                  commit_valid_q, commit_valid_d;
   logic [XLEN-1:0]       commit_pc_q, commit_pc_d;
   logic [INSTRET_W-1:0]  instret_q, instret_d;
   logic [XLEN-1:0]       ld_data;

   wb_load_ext u_load_ext (
      .funct3_i (pend_q.funct3),
      .off_i    (pend_q.off),
      .rdata_i  (dmem_rdata_i),
      .result_o (ld_data)
   );

   // Index, data and PC hold between retires; strobes default low.
   always_comb begin
      state_d        = state_q;
      pend_d         = pend_q;
      rd_wen_d       = 1'b0;
      rd_idx_d       = rd_idx_q;
      rd_wdata_d     = rd_wdata_q;
      commit_valid_d = 1'b0;
      commit_pc_d    = commit_pc_q;
      instret_d      = instret_q;

      case (state_q)
         WB_IDLE: begin
            if (mem_valid_i) begin
               if (mem_is_load_i) begin
                  pend_d.pc     = mem_pc_i;
                  pend_d.rd_wen = mem_rd_wen_i;
                  pend_d.rd_idx = mem_rd_idx_i;
                  pend_d.funct3 = mem_ld_funct3_i;
                  pend_d.off    = mem_alu_res_i[2:0];
                  state_d       = WB_WAIT_LD;
               end else begin
                  commit_valid_d = 1'b1;
                  commit_pc_d    = mem_pc_i;
                  rd_wen_d       = mem_rd_wen_i && (mem_rd_idx_i != REG_X0);
                  rd_idx_d       = mem_rd_idx_i;
                  rd_wdata_d     = mem_alu_res_i;
               end
            end
         end
         WB_WAIT_LD: begin
            if (dmem_rvalid_i) begin
               commit_valid_d = 1'b1;
               commit_pc_d    = pend_q.pc;
               rd_wen_d       = pend_q.rd_wen && (pend_q.rd_idx != REG_X0);
               rd_idx_d       = pend_q.rd_idx;
               rd_wdata_d     = ld_data;
               state_d        = WB_IDLE;
            end
         end
         default: state_d = WB_IDLE;
      endcase

      if (commit_valid_d) begin
         instret_d = instret_q + INSTRET_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= WB_IDLE;
         pend_q         <= '0;
         rd_wen_q       <= 1'b0;
         rd_idx_q       <= '0;
         rd_wdata_q     <= '0;
         commit_valid_q <= 1'b0;
         commit_pc_q    <= '0;
         instret_q      <= '0;
      end else begin
         state_q        <= state_d;
         pend_q         <= pend_d;
         rd_wen_q       <= rd_wen_d;
         rd_idx_q       <= rd_idx_d;
         rd_wdata_q     <= rd_wdata_d;
         commit_valid_q <= commit_valid_d;
         commit_pc_q    <= commit_pc_d;
         instret_q      <= instret_d;
      end
   end

   assign wb_ready_o     = (state_q == WB_IDLE);
   assign rd_wen_o       = rd_wen_q;
   assign rd_idx_o       = rd_idx_q;
   assign rd_wdata_o     = rd_wdata_q;
   assign commit_valid_o = commit_valid_q;
   assign commit_pc_o    = commit_pc_q;
   assign instret_o      = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by random
// ALU/load/idle traffic compared against a simple architectural model.
module tb_wb_stage;
   import wb_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid_i;
   logic        wb_ready_o;
   logic [63:0] mem_pc_i;
   logic        mem_rd_wen_i;
   logic [4:0]  mem_rd_idx_i;
   logic [63:0] mem_alu_res_i;
   logic        mem_is_load_i;
   logic [2:0]  mem_ld_funct3_i;
   logic        dmem_rvalid_i;
   logic [63:0] dmem_rdata_i;
   logic        rd_wen_o;
   logic [4:0]  rd_idx_o;
   logic [63:0] rd_wdata_o;
   logic        commit_valid_o;
   logic [63:0] commit_pc_o;
   logic [63:0] instret_o;

   int checks = 0;
   int errors = 0;

   logic [63:0] m_instret;
   logic [4:0]  m_idx;
   logic [63:0] m_wdata;
   logic [63:0] m_pc;

   localparam logic [63:0] RDATA = 64'h8899AABB_CCDDEEFF;

   always #5 clk = ~clk;

   wb_stage #(.INSTRET_W(64)) dut (
      .clk             (clk),
      .rst             (rst),
      .mem_valid_i     (mem_valid_i),
      .wb_ready_o      (wb_ready_o),
      .mem_pc_i        (mem_pc_i),
      .mem_rd_wen_i    (mem_rd_wen_i),
      .mem_rd_idx_i    (mem_rd_idx_i),
      .mem_alu_res_i   (mem_alu_res_i),
      .mem_is_load_i   (mem_is_load_i),
      .mem_ld_funct3_i (mem_ld_funct3_i),
      .dmem_rvalid_i   (dmem_rvalid_i),
      .dmem_rdata_i    (dmem_rdata_i),
      .rd_wen_o        (rd_wen_o),
      .rd_idx_o        (rd_idx_o),
      .rd_wdata_o      (rd_wdata_o),
      .commit_valid_o  (commit_valid_o),
      .commit_pc_o     (commit_pc_o),
      .instret_o       (instret_o)
   );

   function automatic logic [63:0] rand64();
      return {$urandom(), $urandom()};
   endfunction

   // Architectural load result using shifts/masks and modular arithmetic for sign extension.
   function automatic logic [63:0] model_ld(input logic [2:0] f3, input logic [2:0] off,
                                           input logic [63:0] d);
      int o;
      logic [63:0] b, h, w;
      o = int'(off);
      b = (d >> (8 * o)) & 64'hFF;
      h = (d >> (16 * (o / 2))) & 64'hFFFF;
      w = (d >> (32 * (o / 4))) & 64'hFFFF_FFFF;
      case (f3)
         3'd0:    return (b >= 64'h80) ? b - 64'h100 : b;
         3'd1:    return (h >= 64'h8000) ? h - 64'h1_0000 : h;
         3'd2:    return (w >= 64'h8000_0000) ? w - 64'h1_0000_0000 : w;
         3'd4:    return b;
         3'd5:    return h;
         3'd6:    return w;
         default: return d;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_retire(input string tag, input logic [63:0] pc, input logic wen,
                               input logic [4:0] idx, input logic [63:0] data);
      m_instret = m_instret + 64'd1;
      m_pc      = pc;
      m_idx     = idx;
      m_wdata   = data;
      chk({tag, "_commit"}, 64'(commit_valid_o), 64'd1);
      chk({tag, "_wen"}, 64'(rd_wen_o), 64'(wen && (idx != 5'd0)));
      chk({tag, "_idx"}, 64'(rd_idx_o), 64'(m_idx));
      chk({tag, "_wdata"}, rd_wdata_o, m_wdata);
      chk({tag, "_pc"}, commit_pc_o, m_pc);
      chk({tag, "_instret"}, instret_o, m_instret);
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, "_commit"}, 64'(commit_valid_o), 64'd0);
      chk({tag, "_wen"}, 64'(rd_wen_o), 64'd0);
      chk({tag, "_idx"}, 64'(rd_idx_o), 64'(m_idx));
      chk({tag, "_wdata"}, rd_wdata_o, m_wdata);
      chk({tag, "_pc"}, commit_pc_o, m_pc);
      chk({tag, "_instret"}, instret_o, m_instret);
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      mem_valid_i   = 1'b0;
      dmem_rvalid_i = 1'b0;
      step();
      step();
      rst       = 1'b0;
      m_instret = '0;
      m_idx     = '0;
      m_wdata   = '0;
      m_pc      = '0;
      chk("rst_ready", 64'(wb_ready_o), 64'd1);
      check_quiet("rst");
   endtask

   // Leaves mem_valid_i high so consecutive calls form back-to-back traffic.
   task automatic alu_op(input logic [63:0] pc, input logic wen, input logic [4:0] idx,
                         input logic [63:0] res);
      mem_valid_i     = 1'b1;
      mem_is_load_i   = 1'b0;
      mem_pc_i        = pc;
      mem_rd_wen_i    = wen;
      mem_rd_idx_i    = idx;
      mem_alu_res_i   = res;
      mem_ld_funct3_i = 3'($urandom());
      dmem_rvalid_i   = 1'($urandom());
      dmem_rdata_i    = rand64();
      chk("alu_ready", 64'(wb_ready_o), 64'd1);
      step();
      check_retire("alu", pc, wen, idx, res);
   endtask

   task automatic idle(input logic spurious);
      mem_valid_i   = 1'b0;
      mem_is_load_i = 1'($urandom());
      mem_pc_i      = rand64();
      dmem_rvalid_i = spurious;
      dmem_rdata_i  = rand64();
      step();
      dmem_rvalid_i = 1'b0;
      chk("idle_ready", 64'(wb_ready_o), 64'd1);
      check_quiet("idle");
   endtask

   task automatic load_op(input logic [63:0] pc, input logic wen, input logic [4:0] idx,
                          input logic [63:0] addr, input logic [2:0] f3,
                          input logic [63:0] rdata, input int waitn,
                          input logic [63:0] exp_data);
      mem_valid_i     = 1'b1;
      mem_is_load_i   = 1'b1;
      mem_pc_i        = pc;
      mem_rd_wen_i    = wen;
      mem_rd_idx_i    = idx;
      mem_alu_res_i   = addr;
      mem_ld_funct3_i = f3;
      dmem_rvalid_i   = 1'($urandom());
      dmem_rdata_i    = rand64();
      chk("ld_ready_accept", 64'(wb_ready_o), 64'd1);
      step();
      mem_pc_i      = rand64();
      mem_alu_res_i = rand64();
      dmem_rvalid_i = 1'b0;
      chk("ld_ready_wait", 64'(wb_ready_o), 64'd0);
      check_quiet("ld_wait");
      for (int i = 0; i < waitn; i++) begin
         mem_valid_i   = 1'($urandom());
         mem_is_load_i = 1'($urandom());
         step();
         chk("ld_ready_stall", 64'(wb_ready_o), 64'd0);
         check_quiet("ld_stall");
      end
      mem_valid_i   = 1'b0;
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = rdata;
      chk("ld_ready_rvalid", 64'(wb_ready_o), 64'd0);
      step();
      dmem_rvalid_i = 1'b0;
      dmem_rdata_i  = rand64();
      check_retire("ld", pc, wen, idx, exp_data);
      chk("ld_ready_after", 64'(wb_ready_o), 64'd1);
   endtask

   initial begin
      rst             = 1'b1;
      mem_valid_i     = 1'b0;
      mem_pc_i        = '0;
      mem_rd_wen_i    = 1'b0;
      mem_rd_idx_i    = '0;
      mem_alu_res_i   = '0;
      mem_is_load_i   = 1'b0;
      mem_ld_funct3_i = '0;
      dmem_rvalid_i   = 1'b0;
      dmem_rdata_i    = '0;

      do_reset();

      alu_op(64'h1000, 1'b1, 5'd5, 64'h1234);
      idle(1'b0);

      for (int i = 0; i < 4; i++) begin
         alu_op(64'h2000 + 64'(4 * i), 1'b1, 5'(i + 1), 64'(100 + i));
      end
      idle(1'b0);

      load_op(64'h3000, 1'b1, 5'd6, 64'h101, 3'b000, RDATA, 0, 64'hFFFFFFFF_FFFFFFEE);
      load_op(64'h3004, 1'b1, 5'd7, 64'h107, 3'b100, RDATA, 1, 64'h88);
      load_op(64'h3008, 1'b1, 5'd8, 64'h106, 3'b001, RDATA, 0, 64'hFFFFFFFF_FFFF8899);
      load_op(64'h300C, 1'b1, 5'd9, 64'h104, 3'b110, RDATA, 2, 64'h8899AABB);
      load_op(64'h3010, 1'b1, 5'd10, 64'h100, 3'b010, RDATA, 3, 64'hFFFFFFFF_CCDDEEFF);
      alu_op(64'h3014, 1'b1, 5'd11, 64'h55);
      load_op(64'h3018, 1'b1, 5'd12, 64'h105, 3'b011, RDATA, 0, RDATA);
      load_op(64'h301C, 1'b1, 5'd13, 64'h103, 3'b111, RDATA, 0, RDATA);
      idle(1'b1);
      idle(1'b1);

      alu_op(64'h4000, 1'b1, 5'd0, 64'hDEAD);
      load_op(64'h4004, 1'b1, 5'd0, 64'h0, 3'b011, RDATA, 1, RDATA);
      idle(1'b0);

      // Reset while a load is outstanding: the load must vanish entirely.
      mem_valid_i     = 1'b1;
      mem_is_load_i   = 1'b1;
      mem_pc_i        = 64'h5000;
      mem_rd_wen_i    = 1'b1;
      mem_rd_idx_i    = 5'd3;
      mem_alu_res_i   = 64'h0;
      mem_ld_funct3_i = 3'b011;
      step();
      mem_valid_i = 1'b0;
      chk("rstld_wait", 64'(wb_ready_o), 64'd0);
      rst = 1'b1;
      step();
      rst       = 1'b0;
      m_instret = '0;
      m_idx     = '0;
      m_wdata   = '0;
      m_pc      = '0;
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = RDATA;
      step();
      dmem_rvalid_i = 1'b0;
      chk("rstld_ready", 64'(wb_ready_o), 64'd1);
      check_quiet("rstld");

      for (int n = 0; n < 80; n++) begin
         int kind;
         logic [63:0] addr;
         logic [63:0] rd;
         logic [2:0]  f3;
         kind = $urandom_range(0, 3);
         addr = rand64();
         rd   = rand64();
         f3   = 3'($urandom());
         if (kind <= 1) begin
            alu_op(rand64(), 1'($urandom()), 5'($urandom()), rand64());
         end else if (kind == 2) begin
            load_op(rand64(), 1'($urandom()), 5'($urandom()), addr, f3, rd,
                    $urandom_range(0, 3), model_ld(f3, addr[2:0], rd));
         end else begin
            idle(1'($urandom()));
         end
      end
      idle(1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
